// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter sharing one fixed-latency ALU between two requesters.
// Optional idle-operand hold register enabled by defining ALU_OPERAND_HOLD_EN.
module alu_issue_arbiter #(
  parameter int LAT = 3,
  parameter int W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_sel,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [3:0]   req0_shamt,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_sel,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [3:0]   req1_shamt,
  input  logic         req1_cin,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_shamt,
  output logic [3:0]   alu_sel,
  output logic         alu_cin,
  input  logic [31:0]  alu_result,
  input  logic [15:0]  alu_remainder,
  input  logic         alu_carry,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [31:0]  rsp_result,
  output logic [15:0]  rsp_remainder,
  output logic         rsp_carry,
  output logic         rsp_err,
  output logic [2:0]   inflight
);

  typedef struct packed {
    logic valid;
    logic id;
    logic err;
  } tag_t;

  logic         last_grant_r;
  logic         grant0_s;
  logic         grant1_s;
  logic         issue_s;
  logic [3:0]   sel_s;
  logic [W-1:0] a_s;
  logic [W-1:0] b_s;
  logic [3:0]   shamt_s;
  logic         cin_s;
  logic         err_s;
  logic         rsp_done_s;
  tag_t         pop_s;
  tag_t         tag_r [LAT];

`ifdef ALU_OPERAND_HOLD_EN
  logic [W-1:0] hold_a_r;
  logic [W-1:0] hold_b_r;
  logic [3:0]   hold_shamt_r;
  logic         hold_cin_r;
`endif

  // Round-robin grant: on contention the requester not granted last wins
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      grant0_s = last_grant_r;
      grant1_s = ~last_grant_r;
    end else begin
      grant0_s = req0_valid;
      grant1_s = req1_valid;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign issue_s    = grant0_s | grant1_s;

  // Granted request mux and error classification
  always_comb begin
    sel_s   = grant1_s ? req1_sel   : req0_sel;
    a_s     = grant1_s ? req1_a     : req0_a;
    b_s     = grant1_s ? req1_b     : req0_b;
    shamt_s = grant1_s ? req1_shamt : req0_shamt;
    cin_s   = grant1_s ? req1_cin   : req0_cin;
    err_s   = (sel_s > 4'd9) || ((sel_s == 4'd3) && (b_s == {W{1'b0}}));
  end

  // ALU input drive: granted op, idle (nop select), or all-zero in reset
  always_comb begin
    alu_a     = {W{1'b0}};
    alu_b     = {W{1'b0}};
    alu_shamt = 4'd0;
    alu_cin   = 1'b0;
    alu_sel   = 4'd0;
    if (rst) begin
      alu_sel = 4'd0;
    end else if (issue_s) begin
      alu_a     = a_s;
      alu_b     = b_s;
      alu_shamt = shamt_s;
      alu_cin   = cin_s;
      alu_sel   = (sel_s > 4'd9) ? 4'b1111 : sel_s;
    end else begin
      alu_sel = 4'b1111;
`ifdef ALU_OPERAND_HOLD_EN
      alu_a     = hold_a_r;
      alu_b     = hold_b_r;
      alu_shamt = hold_shamt_r;
      alu_cin   = hold_cin_r;
`else
      alu_a     = {W{1'b0}};
      alu_b     = {W{1'b0}};
      alu_shamt = 4'd0;
      alu_cin   = 1'b0;
`endif
    end
  end

`ifdef ALU_OPERAND_HOLD_EN
  // Keep the last issued operands on the ALU inputs to avoid idle toggling
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_a_r     <= {W{1'b0}};
      hold_b_r     <= {W{1'b0}};
      hold_shamt_r <= 4'd0;
      hold_cin_r   <= 1'b0;
    end else if (issue_s) begin
      hold_a_r     <= a_s;
      hold_b_r     <= b_s;
      hold_shamt_r <= shamt_s;
      hold_cin_r   <= cin_s;
    end
  end
`endif

  // Arbitration history and tag pipeline aligned with the ALU latency
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
      for (int i = 0; i < LAT; i++) tag_r[i] <= '0;
    end else begin
      if (issue_s) last_grant_r <= grant1_s;
      tag_r[0] <= {issue_s, grant1_s, err_s};
      for (int i = 1; i < LAT; i++) tag_r[i] <= tag_r[i-1];
    end
  end

  assign pop_s      = tag_r[LAT-1];
  assign rsp_done_s = rsp0_valid | rsp1_valid;

  // Response capture; rsp_* holds between responses
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid    <= 1'b0;
      rsp1_valid    <= 1'b0;
      rsp_result    <= 32'd0;
      rsp_remainder <= 16'd0;
      rsp_carry     <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      rsp0_valid <= pop_s.valid & ~pop_s.id;
      rsp1_valid <= pop_s.valid & pop_s.id;
      if (pop_s.valid) begin
        rsp_result    <= alu_result;
        rsp_remainder <= alu_remainder;
        rsp_carry     <= alu_carry;
        rsp_err       <= pop_s.err;
      end
    end
  end

  // Outstanding count: issue to response pulse, inclusive
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 3'd0;
    end else begin
      case ({issue_s, rsp_done_s})
        2'b10:   inflight <= inflight + 3'd1;
        2'b01:   inflight <= inflight - 3'd1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
